// File: rtl/rom_reverse_lookup_pkg.sv
// Shared definitions for the code ROM and its reverse lookup.
package rom_pkg;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 6;
  localparam int ROM_MULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Table contents: entry[addr] = addr*ROM_MULT. The full product is returned
  // so a block built with a non-default code width can truncate to its own
  // DATA_W; the forward ROM and the reverse lookup both derive from here.
  function automatic logic [31:0] rom_entry(input logic [31:0] addr);
    return addr * ROM_MULT;
  endfunction

endpackage

// File: rtl/rom_reverse_lookup_lut.sv
// Combinational index -> code table, used as the compare source for the scan.
module rom_lut #(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] entry
);
  import rom_pkg::*;

  // Truncation to DATA_W is what can make entries alias for narrow codes.
  assign entry = DATA_W'(rom_entry(32'(addr)));

endmodule

// File: rtl/rom_reverse_lookup.sv
// Reverse lookup of the code ROM: scans one table entry per clock from index 0
// and returns the lowest matching index, or a miss after the last entry.
module rom_reverse_lookup #(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_hit,
  output logic [CNT_W-1:0]  lookup_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  import rom_pkg::*;

  localparam logic [ADDR_W-1:0] IDX_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] code_q;
  logic [DATA_W-1:0] entry;

  rom_lut #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lut (
    .addr  (idx),
    .entry (entry)
  );

  // Lookup FSM with registered handshake/result outputs and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_hit    <= 1'b0;
      idx        <= '0;
      code_q     <= '0;
      lookup_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Capture so later changes on in_code cannot disturb the scan.
            code_q   <= in_code;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (entry == code_q) begin
            // Scanning upward makes the lowest duplicate index win.
            out_addr  <= idx;
            out_hit   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == IDX_MAX) begin
            out_addr  <= '0;
            out_hit   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
            if (lookup_cnt != CNT_MAX) lookup_cnt <= lookup_cnt + 1'b1;
            if (!out_hit && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reverse_lookup.sv
// Directed bench for rom_reverse_lookup with a result scoreboard.
module tb_rom_reverse_lookup;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_code = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_addr;
  logic       out_hit;
  logic [7:0] lookup_cnt;
  logic [7:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_lookup = 0;
  int exp_miss = 0;

  typedef struct {
    logic [2:0] addr;
    logic       hit;
    int         lat;
  } exp_t;

  exp_t sb[$];

  rom_reverse_lookup dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_hit    (out_hit),
    .lookup_cnt (lookup_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference table: entry[k] = 5*k in 6 bits; first match wins.
  function automatic exp_t model(input logic [5:0] code);
    exp_t e;
    e.addr = 3'd0;
    e.hit  = 1'b0;
    e.lat  = 8;
    for (int k = 7; k >= 0; k--) begin
      logic [5:0] ent;
      ent = 6'((k * 5) % 64);
      if (ent == code) begin
        e.addr = 3'(k);
        e.hit  = 1'b1;
        e.lat  = 1 + k;
      end
    end
    return e;
  endfunction

  // Issue one request, measure latency, check result, hold DONE for 'hold'
  // cycles (pulsing in_valid), then complete the handshake.
  task automatic lookup(input logic [5:0] code, input int hold);
    exp_t e;
    int   n;
    logic v0, h0;
    logic [2:0] a0;
    sb.push_back(model(code));
    chk("in_ready_idle", in_ready, 1);
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 6'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    e = sb.pop_front();
    chk("out_valid", out_valid, 1);
    chk("latency", n, e.lat);
    chk("out_addr", out_addr, e.addr);
    chk("out_hit", out_hit, e.hit);
    v0 = out_valid; a0 = out_addr; h0 = out_hit;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_code  = 6'd0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, v0);
      chk("hold_addr", out_addr, a0);
      chk("hold_hit", out_hit, h0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_lookup_cnt", lookup_cnt, exp_lookup);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_lookup < 255) exp_lookup++;
    if (!e.hit && exp_miss < 255) exp_miss++;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("lookup_cnt", lookup_cnt, exp_lookup);
    chk("miss_cnt", miss_cnt, exp_miss);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_lookup_cnt", lookup_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Hits at first, last and middle entries, then a miss
    lookup(6'd0, 0);
    lookup(6'd35, 0);
    lookup(6'd20, 0);
    lookup(6'd7, 0);
    lookup(6'd5, 0);
    lookup(6'd63, 0);

    // Back-pressure in DONE with in_valid pulses that must be ignored
    lookup(6'd15, 5);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_hold", in_ready, 1);
    chk("no_spurious_valid", out_valid, 0);

    // Reset in the middle of a scan of code 30
    in_code  = 6'd30;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midscan_busy", in_ready, 0);
    chk("midscan_no_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    exp_lookup = 0;
    exp_miss   = 0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_hit", out_hit, 0);
    chk("midrst_lookup_cnt", lookup_cnt, exp_lookup);
    chk("midrst_miss_cnt", miss_cnt, exp_miss);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lookup(6'd30, 0);

    // Saturation of both counters
    for (int i = 0; i < 300; i++) lookup(6'd7, 0);
    chk("sat_lookup_cnt", lookup_cnt, 255);
    chk("sat_miss_cnt", miss_cnt, 255);
    lookup(6'd10, 0);
    chk("sat_hit_lookup_cnt", lookup_cnt, 255);
    chk("sat_hit_miss_cnt", miss_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
